// File: rtl/branch_resolve_if.sv
// branch_resolve_if: E-stage branch inputs and M-stage resolution outputs.
// master drives E inputs/flushM and observes M results; slave is the resolver.
interface branch_resolve_if #(
   parameter int GHR_W = 4,
   parameter int CNT_W = 32
);
   logic             flushM;
   logic             branchE;
   logic [2:0]       branch_opE;
   logic [31:0]      rs_valE;
   logic [31:0]      rt_valE;
   logic [31:0]      pcE;
   logic [31:0]      imm_extE;
   logic             pred_takeE;
   logic             branchM;
   logic             actual_takeM;
   logic             pred_takeM;
   logic [31:0]      pcM;
   logic             mispredictM;
   logic [31:0]      redirect_pcM;
   logic             flush_reqD;
   logic [GHR_W-1:0] ghr_realM;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] mis_cnt;

   modport master (
      output flushM, branchE, branch_opE, rs_valE, rt_valE,
      output pcE, imm_extE, pred_takeE,
      input  branchM, actual_takeM, pred_takeM, pcM, mispredictM,
      input  redirect_pcM, flush_reqD, ghr_realM, br_cnt, mis_cnt
   );

   modport slave (
      input  flushM, branchE, branch_opE, rs_valE, rt_valE,
      input  pcE, imm_extE, pred_takeE,
      output branchM, actual_takeM, pred_takeM, pcM, mispredictM,
      output redirect_pcM, flush_reqD, ghr_realM, br_cnt, mis_cnt
   );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: E-stage branch evaluation, E->M register, M-stage
// mispredict/redirect and committed global history.
// Ports: clk, rst (sync, active-low), bus (branch_resolve_if.slave).
// Optional BR_STATS_EN macro adds saturating br_cnt/mis_cnt counters.
module branch_resolve #(
   parameter int GHR_W = 4,
   parameter int CNT_W = 32
) (
   input  logic clk,
   input  logic rst,
   branch_resolve_if.slave bus
);
   typedef enum logic {IDLE, RECOVER} state_t;

   state_t           state;
   state_t           state_nx;
   logic             taken_e;
   logic [31:0]      target_e;
   logic             rs_zero;
   logic             rs_neg;
   logic             load_valid;
   logic             mispredict;
   logic             hist_upd;
   logic             branch_q;
   logic             act_q;
   logic             pred_q;
   logic [31:0]      pc_q;
   logic [31:0]      target_q;
   logic [GHR_W-1:0] ghr_q;

   assign rs_zero = (bus.rs_valE == 32'd0);
   assign rs_neg  = bus.rs_valE[31];

   always_comb begin
      taken_e = 1'b0;
      unique case (bus.branch_opE)
         3'b000:  taken_e = (bus.rs_valE == bus.rt_valE);
         3'b001:  taken_e = (bus.rs_valE != bus.rt_valE);
         3'b010:  taken_e = !rs_neg;
         3'b011:  taken_e = !rs_neg && !rs_zero;
         3'b100:  taken_e = rs_neg || rs_zero;
         3'b101:  taken_e = rs_neg;
         default: taken_e = 1'b0;
      endcase
   end

   assign target_e = bus.pcE + 32'd4 + (bus.imm_extE << 2);

   // Delay-slot branch behind a mispredict, and anything during RECOVER,
   // is wrong-path and must never resolve.
   assign load_valid = bus.branchE && !mispredict && (state == IDLE);

   assign mispredict = branch_q && (act_q != pred_q) && (state == IDLE);
   assign hist_upd   = branch_q && (state == IDLE);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (mispredict) state_nx = RECOVER;
         RECOVER: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         branch_q <= 1'b0;
         act_q    <= 1'b0;
         pred_q   <= 1'b0;
         pc_q     <= 32'd0;
         target_q <= 32'd0;
         ghr_q    <= '0;
      end else begin
         state <= state_nx;
         if (hist_upd)
            ghr_q <= {ghr_q[GHR_W-2:0], act_q};
         if (bus.flushM) begin
            branch_q <= 1'b0;
            act_q    <= 1'b0;
            pred_q   <= 1'b0;
            pc_q     <= 32'd0;
            target_q <= 32'd0;
         end else begin
            branch_q <= load_valid;
            act_q    <= taken_e;
            pred_q   <= bus.pred_takeE;
            pc_q     <= bus.pcE;
            target_q <= target_e;
         end
      end
   end

   assign bus.branchM      = branch_q;
   assign bus.actual_takeM = act_q;
   assign bus.pred_takeM   = pred_q;
   assign bus.pcM          = pc_q;
   assign bus.mispredictM  = mispredict;
   assign bus.flush_reqD   = mispredict;
   assign bus.ghr_realM    = ghr_q;
   // Fall-through skips the delay slot.
   assign bus.redirect_pcM = act_q ? target_q : (pc_q + 32'd8);

`ifdef BR_STATS_EN
   logic [CNT_W-1:0] br_q;
   logic [CNT_W-1:0] mis_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         br_q  <= '0;
         mis_q <= '0;
      end else begin
         if (hist_upd && !(&br_q))
            br_q <= br_q + CNT_W'(1);
         if (mispredict && !(&mis_q))
            mis_q <= mis_q + CNT_W'(1);
      end
   end

   assign bus.br_cnt  = br_q;
   assign bus.mis_cnt = mis_q;
`else
   assign bus.br_cnt  = {CNT_W{1'b0}};
   assign bus.mis_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and randomized checks of branch_resolve
// against a cycle-level reference model of the resolution rules.
module tb_branch_resolve;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

`ifdef BR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   branch_resolve_if #(.GHR_W(4), .CNT_W(32)) bus ();

   branch_resolve #(.GHR_W(4), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state (what M should hold after each edge)
   bit          m_br;
   bit          m_act;
   bit          m_pred;
   logic [31:0] m_pc;
   logic [31:0] m_tgt;
   int          ghr;
   bit          rec;
   longint      nbr;
   longint      nmis;

   function automatic bit ref_take(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
      int s;
      s = a;
      case (op)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd2: return s >= 0;
         3'd3: return s > 0;
         3'd4: return s <= 0;
         3'd5: return s < 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit exp_mis();
      return m_br && (m_act != m_pred) && !rec;
   endfunction

   function automatic logic [31:0] exp_redir();
      return m_act ? m_tgt : m_pc + 32'd8;
   endfunction

   task automatic model_edge();
      bit mis;
      bit upd;
      mis = exp_mis();
      upd = m_br && !rec;
      if (!rst) begin
         m_br = 0; m_act = 0; m_pred = 0;
         m_pc = 0; m_tgt = 0;
         ghr = 0; rec = 0; nbr = 0; nmis = 0;
      end else begin
         if (upd) begin
            ghr = ((ghr << 1) | int'(m_act)) % 16;
            if (nbr < 64'hFFFF_FFFF) nbr++;
         end
         if (mis && nmis < 64'hFFFF_FFFF) nmis++;
         if (bus.flushM) begin
            m_br = 0; m_act = 0; m_pred = 0;
            m_pc = 0; m_tgt = 0;
         end else begin
            m_br   = bus.branchE && !rec && !mis;
            m_act  = ref_take(bus.branch_opE, bus.rs_valE, bus.rt_valE);
            m_pred = bus.pred_takeE;
            m_pc   = bus.pcE;
            m_tgt  = bus.pcE + 32'd4 + bus.imm_extE * 32'd4;
         end
         rec = mis;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input bit br, input logic [2:0] op,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input bit pred, input bit fl);
      bus.branchE    = br;
      bus.branch_opE = op;
      bus.rs_valE    = rs;
      bus.rt_valE    = rt;
      bus.pcE        = pc;
      bus.imm_extE   = imm;
      bus.pred_takeE = pred;
      bus.flushM     = fl;
   endtask

   task automatic idle();
      drive(0, 3'd7, 0, 0, 32'h1000, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      tick();
      tick();
      checks++;
      if (bus.branchM !== 1'b0 || bus.mispredictM !== 1'b0 ||
          bus.flush_reqD !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctl br=%b mis=%b fl=%b want 0 0 0",
                  bus.branchM, bus.mispredictM, bus.flush_reqD);
      end
      checks++;
      if (bus.pcM !== 32'd0 || bus.ghr_realM !== 4'd0 ||
          bus.br_cnt !== 32'd0 || bus.mis_cnt !== 32'd0) begin
         failures++;
         $display("FAIL reset_regs pc=%h ghr=%b br=%0d mis=%0d want 0",
                  bus.pcM, bus.ghr_realM, bus.br_cnt, bus.mis_cnt);
      end
      rst = 1'b1;
   endtask

   task automatic test_beq();
      drive(1, 3'd0, 5, 5, 32'h100, 3, 1, 0);
      tick();
      checks++;
      if (bus.branchM !== 1'b1 || bus.actual_takeM !== 1'b1 ||
          bus.mispredictM !== 1'b0) begin
         failures++;
         $display("FAIL beq_m br=%b act=%b mis=%b want 1 1 0",
                  bus.branchM, bus.actual_takeM, bus.mispredictM);
      end
      checks++;
      if (bus.redirect_pcM !== 32'h110) begin
         failures++;
         $display("FAIL beq_tgt got=%h want=110", bus.redirect_pcM);
      end
      idle();
      tick();
      checks++;
      if (bus.ghr_realM !== 4'b0001) begin
         failures++;
         $display("FAIL beq_ghr got=%b want=0001", bus.ghr_realM);
      end
   endtask

   task automatic test_bne_mispredict();
      drive(1, 3'd1, 7, 7, 32'h200, 5, 1, 0);
      tick();
      checks++;
      if (bus.mispredictM !== 1'b1 || bus.flush_reqD !== 1'b1 ||
          bus.redirect_pcM !== 32'h208) begin
         failures++;
         $display("FAIL bne_mis mis=%b fl=%b pc=%h want 1 1 208",
                  bus.mispredictM, bus.flush_reqD, bus.redirect_pcM);
      end
      drive(1, 3'd1, 7, 7, 32'h204, 5, 1, 0);
      tick();
      checks++;
      if (bus.mispredictM !== 1'b0 || bus.branchM !== 1'b0) begin
         failures++;
         $display("FAIL bne_recover mis=%b br=%b want 0 0",
                  bus.mispredictM, bus.branchM);
      end
      checks++;
      if (bus.ghr_realM !== 4'b0010) begin
         failures++;
         $display("FAIL bne_ghr got=%b want=0010", bus.ghr_realM);
      end
      idle();
      tick();
   endtask

   task automatic test_bltz();
      drive(1, 3'd5, 32'hFFFF_FFFF, 0, 32'h300, 32'hFFFF_FFFE, 0, 0);
      tick();
      checks++;
      if (bus.actual_takeM !== 1'b1 || bus.redirect_pcM !== 32'h2FC ||
          bus.mispredictM !== 1'b1) begin
         failures++;
         $display("FAIL bltz act=%b pc=%h mis=%b want 1 2fc 1",
                  bus.actual_takeM, bus.redirect_pcM, bus.mispredictM);
      end
      idle();
      tick();
      tick();
   endtask

   task automatic test_flush();
      logic [3:0]  g0;
      logic [31:0] b0;
      g0 = bus.ghr_realM;
      b0 = bus.br_cnt;
      drive(1, 3'd0, 1, 1, 32'h400, 2, 0, 1);
      tick();
      checks++;
      if (bus.branchM !== 1'b0 || bus.mispredictM !== 1'b0) begin
         failures++;
         $display("FAIL flush_m br=%b mis=%b want 0 0",
                  bus.branchM, bus.mispredictM);
      end
      idle();
      tick();
      checks++;
      if (bus.ghr_realM !== g0 || bus.br_cnt !== b0) begin
         failures++;
         $display("FAIL flush_hist ghr=%b br=%0d want %b %0d",
                  bus.ghr_realM, bus.br_cnt, g0, b0);
      end
   endtask

   task automatic test_back_to_back();
      drive(1, 3'd1, 9, 9, 32'h500, 4, 1, 0);
      tick();
      checks++;
      if (bus.flush_reqD !== 1'b1) begin
         failures++;
         $display("FAIL b2b_first fl=%b want 1", bus.flush_reqD);
      end
      drive(1, 3'd1, 3, 3, 32'h504, 4, 1, 0);
      tick();
      checks++;
      if (bus.branchM !== 1'b0 || bus.flush_reqD !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drop br=%b fl=%b want 0 0",
                  bus.branchM, bus.flush_reqD);
      end
      idle();
      tick();
      checks++;
      if (bus.flush_reqD !== 1'b0) begin
         failures++;
         $display("FAIL b2b_noflush fl=%b want 0", bus.flush_reqD);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, 3'd0, i, i, 32'h600 + i * 8, 1, 1, 0);
         tick();
      end
      idle();
      tick();
      checks++;
      if (bus.ghr_realM !== 4'b1111 || ghr != 15) begin
         failures++;
         $display("FAIL b2b_ghr got=%b want=1111", bus.ghr_realM);
      end
   endtask

   task automatic test_stats();
      rst = 1'b0;
      idle();
      tick();
      rst = 1'b1;
      drive(1, 3'd0, 2, 2, 32'h700, 1, 1, 0);
      tick();
      drive(1, 3'd2, 0, 0, 32'h708, 1, 1, 0);
      tick();
      drive(1, 3'd1, 4, 4, 32'h710, 1, 1, 0);
      tick();
      idle();
      tick();
      tick();
      checks++;
      if (bus.br_cnt !== (STATS ? 32'd3 : 32'd0) ||
          bus.mis_cnt !== (STATS ? 32'd1 : 32'd0)) begin
         failures++;
         $display("FAIL stats_cnt br=%0d mis=%0d want %0d %0d",
                  bus.br_cnt, bus.mis_cnt, STATS ? 3 : 0, STATS ? 1 : 0);
      end
      drive(1, 3'd0, 1, 1, 32'h720, 1, 1, 0);
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (bus.br_cnt !== 32'd0 || bus.mis_cnt !== 32'd0 ||
          bus.ghr_realM !== 4'd0 || bus.branchM !== 1'b0) begin
         failures++;
         $display("FAIL stats_rst br=%0d mis=%0d ghr=%b bm=%b want 0",
                  bus.br_cnt, bus.mis_cnt, bus.ghr_realM, bus.branchM);
      end
      rst = 1'b1;
      idle();
      tick();
   endtask

   task automatic test_random();
      logic [31:0] pool [6];
      logic [31:0] rs;
      logic [31:0] rt;
      pool[0] = 0;
      pool[1] = 1;
      pool[2] = 32'hFFFF_FFFF;
      pool[3] = 32'h8000_0000;
      pool[4] = 32'h7FFF_FFFF;
      pool[5] = 32'h1234;
      for (int i = 0; i < 400; i++) begin
         rs = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)]
                                          : $urandom;
         rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
         rst = ($urandom_range(0, 40) != 0);
         drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
               rs, rt, $urandom, $urandom,
               $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
         tick();
         checks++;
         if (bus.branchM !== m_br || bus.actual_takeM !== m_act ||
             bus.pred_takeM !== m_pred || bus.pcM !== m_pc) begin
            failures++;
            $display("FAIL rnd_m i=%0d got %b%b%b %h want %b%b%b %h",
                     i, bus.branchM, bus.actual_takeM, bus.pred_takeM,
                     bus.pcM, m_br, m_act, m_pred, m_pc);
         end
         checks++;
         if (bus.mispredictM !== exp_mis() ||
             bus.flush_reqD !== exp_mis() ||
             bus.redirect_pcM !== exp_redir()) begin
            failures++;
            $display("FAIL rnd_mis i=%0d got %b%b %h want %b %h",
                     i, bus.mispredictM, bus.flush_reqD,
                     bus.redirect_pcM, exp_mis(), exp_redir());
         end
         checks++;
         if (bus.ghr_realM !== 4'(ghr) ||
             bus.br_cnt !== (STATS ? 32'(nbr) : 32'd0) ||
             bus.mis_cnt !== (STATS ? 32'(nmis) : 32'd0)) begin
            failures++;
            $display("FAIL rnd_hist i=%0d ghr=%b br=%0d mis=%0d want %0d",
                     i, bus.ghr_realM, bus.br_cnt, bus.mis_cnt, ghr);
         end
      end
      rst = 1'b1;
      idle();
      tick();
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      m_br = 0; m_act = 0; m_pred = 0;
      m_pc = 0; m_tgt = 0;
      ghr = 0; rec = 0; nbr = 0; nmis = 0;
      idle();
      test_reset();
      test_beq();
      test_bne_mispredict();
      test_bltz();
      test_flush();
      test_back_to_back();
      test_stats();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-to-memory branch resolution unit for the 5-stage MIPS pipeline, paired with the global-history predictor.
- In E it evaluates the branch condition and target, then registers the result into M.
- In M it compares the actual outcome with the prediction carried down the pipe, and on a mispredict issues the redirect PC and a D-stage flush request.
- It maintains the committed (real) 4-bit global history and feeds it back to the predictor for PHT update and GHT recovery.

Parameters:
- GHR_W, 4, width of the committed global history register.
- CNT_W, 32, width of the statistics counters (only used with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- flushM  in  1  hazard-unit clear of the E->M register.
- branchE  in  1  instruction in E is a conditional branch.
- branch_opE  in  3  condition: 000 beq, 001 bne, 010 bgez, 011 bgtz, 100 blez, 101 bltz; 110/111 never taken.
- rs_valE  in  32  forwarded rs operand.
- rt_valE  in  32  forwarded rt operand.
- pcE  in  32  PC of the instruction in E.
- imm_extE  in  32  sign-extended immediate.
- pred_takeE  in  1  prediction made in D, piped to E.
- branchM  out  1  registered branch valid in M.
- actual_takeM  out  1  registered resolved outcome.
- pred_takeM  out  1  registered prediction.
- pcM  out  32  registered PC.
- mispredictM  out  1  branchM & (actual_takeM != pred_takeM), masked in RECOVER.
- redirect_pcM  out  32  correct fetch PC on mispredict.
- flush_reqD  out  1  equals mispredictM.
- ghr_realM  out  GHR_W  committed history.
- br_cnt  out  CNT_W  branches resolved.
- mis_cnt  out  CNT_W  mispredicts.

Behaviour:
- Reset (rst==0 at a clock edge):
  - All M registers clear: branchM, actual_takeM, pred_takeM = 0; pcM = 0; target register = 0.
  - ghr_realM = 0; FSM = IDLE; counters = 0.
  - Consequently mispredictM, flush_reqD = 0 during and after reset.
- E stage (combinational):
  - Outcome:
    - beq: taken when rs==rt.
    - bne: taken when rs!=rt.
    - bgez/bgtz/blez/bltz: signed compare of rs against 0.
    - Unused encodings: not taken.
  - targetE = pcE + 4 + (imm_extE << 2), 32-bit, wrap-around ignored.
  - fallE = pcE + 8, which skips the delay slot.
- E->M register:
  - Loads every cycle; no stall input, M never stalls.
  - flushM=1 loads zeros (bubble).
  - In RECOVER, branch valid is loaded as 0 so a wrong-path branch cannot resolve. The other fields still load.
- redirect_pcM (combinational from M registers):
  - actual_takeM=1 selects the registered target.
  - actual_takeM=0 selects the registered fall-through.
- Latency:
  - E inputs appear on M outputs 1 cycle later.
  - mispredictM, flush_reqD and redirect_pcM are combinational in that same M cycle.
- Global history:
  - On each edge with branchM=1 (and FSM in IDLE): ghr_realM <= {ghr_realM[GHR_W-2:0], actual_takeM}.
  - A branch with flushM applied never updates history.
- FSM:
  - IDLE -> RECOVER on mispredictM=1.
  - RECOVER -> IDLE unconditionally after 1 cycle.
  - In RECOVER: mispredictM is forced 0 and history is frozen. This is a defensive guard against back-to-back wrong-path resolution.
- Simultaneous events:
  - Mispredict in M together with branchE=1: the E branch is dropped (branchM=0 next cycle); the delay-slot instruction itself is non-branch by ISA.
  - Reset overrides everything, including a mid-RECOVER state, which returns to IDLE.

Optional Feature:
- BR_STATS_EN defined:
  - br_cnt increments on every history update.
  - mis_cnt increments on every asserted mispredictM.
  - Both saturate at all-ones and clear on reset.
- BR_STATS_EN undefined: br_cnt and mis_cnt are tied to 0 and no counter flops are inferred.

Test Plan:
- Reset released, then beq with rs=rt=5, pcE=0x100, imm=3, pred=1:
  - Next cycle: branchM=1, actual_takeM=1, mispredictM=0, ghr_realM=0001 after the following edge.
- bne with rs=rt=7, pred=1, pcE=0x200:
  - M cycle: mispredictM=1, flush_reqD=1, redirect_pcM=0x208.
  - Following cycle: FSM in RECOVER, mispredictM=0.
- bltz with rs=0xFFFFFFFF, pred=0, pcE=0x300, imm=0xFFFFFFFE:
  - M cycle: actual_takeM=1, redirect_pcM=0x2FC.
- Branch in E with flushM=1 at the edge:
  - Next cycle: branchM=0, ghr_realM unchanged, counters unchanged.
- Mispredict in M, with a further mispredicting branch presented in E the same cycle:
  - Next cycle: branchM=0 and no second flush_reqD.
  - Four correct taken branches then give ghr_realM=1111.
- With BR_STATS_EN:
  - 3 branches, 1 mispredicted, give br_cnt=3, mis_cnt=1.
  - Asserting rst=0 mid-stream returns both counters and ghr_realM to 0 next edge.
